// File: rtl/mlp_ctrl_pkg.sv
// Shared types and widths for the MLP count sequencer and its helpers.
package mlp_ctrl_pkg;
  localparam int CW = 13;
  localparam int LW = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    RUN      = 3'd2,
    SEG_WAIT = 3'd3,
    SEG_ADV  = 3'd4,
    LDONE    = 3'd5,
    DONE     = 3'd6
  } state_t;
endpackage

// File: rtl/mlp_seg_bound.sv
// Saturating segment-boundary adder: y = a + b, forced to all-ones when the
// sum reaches lim or carries out, so a sub boundary never lands past the end.
module mlp_seg_bound
  import mlp_ctrl_pkg::*;
(
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] lim,
  output logic [CW-1:0] y
);
  logic [CW:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum[CW] || (sum[CW-1:0] >= lim)) ? '1 : sum[CW-1:0];
  end
endmodule

// File: rtl/mlp_count_seq.sv
// Layer/segment sequencer driving rip_counter_13b. Optional stall counter is
// built when SEQ_STALL_CNT_EN is defined; otherwise stall_cyc is tied to 0.
module mlp_count_seq
  import mlp_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] num_layers,
  input  logic [CW-1:0] layer_len_i,
  input  logic [CW-1:0] seg_len_i,
  output logic [LW-1:0] layer_idx,
  output logic          cnt_rst_n,
  output logic          cnt_en,
  output logic [CW-1:0] cnt_end,
  output logic [CW-1:0] cnt_end_sub,
  input  logic          cnt_fin,
  input  logic          cnt_fin_sub,
  output logic          seg_valid,
  input  logic          seg_ready,
  output logic          seg_last,
  output logic [CW-1:0] seg_idx,
  output logic          layer_done,
  output logic          done,
  output logic          busy,
  output logic [15:0]   stall_cyc,
  output state_t        state_dbg
);
  state_t        state, state_n;
  logic [LW-1:0] num_layers_q;
  logic          seg_last_q;
  logic          fs_q;
  logic          fs_rise;
  logic [CW-1:0] bnd_a, bnd_b, bnd_lim, bnd_y;

  assign fs_rise    = cnt_fin_sub & ~fs_q;
  assign cnt_en     = (state == RUN) & ~cnt_fin & ~fs_rise;
  // Handshake: seg_valid rises in SEG_WAIT and holds, together with seg_idx
  // and seg_last, until a cycle with seg_ready high; that cycle is the transfer.
  assign seg_valid  = (state == SEG_WAIT);
  assign seg_last   = seg_last_q & seg_valid;
  assign layer_done = (state == LDONE);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  // In CLR the limit is the new layer end, not the stale cnt_end register.
  assign bnd_a   = (state == CLR) ? (seg_len_i - CW'(1))   : cnt_end_sub;
  assign bnd_b   = (state == CLR) ? '0                     : seg_len_i;
  assign bnd_lim = (state == CLR) ? (layer_len_i - CW'(1)) : cnt_end;

  mlp_seg_bound u_bound (
    .a   (bnd_a),
    .b   (bnd_b),
    .lim (bnd_lim),
    .y   (bnd_y)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = CLR;
      CLR:      state_n = (layer_len_i == '0) ? LDONE : RUN;
      RUN:      if (cnt_fin || fs_rise) state_n = SEG_WAIT;
      SEG_WAIT: if (seg_ready) state_n = seg_last_q ? LDONE : SEG_ADV;
      SEG_ADV:  state_n = RUN;
      LDONE:    state_n = (layer_idx == num_layers_q) ? DONE : CLR;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      num_layers_q <= '0;
      layer_idx    <= '0;
      cnt_end      <= '0;
      cnt_end_sub  <= '0;
      seg_idx      <= '0;
      seg_last_q   <= 1'b0;
      fs_q         <= 1'b0;
      cnt_rst_n    <= 1'b0;
    end else begin
      state <= state_n;
      fs_q  <= cnt_fin_sub;
      case (state)
        IDLE: if (start) begin
          num_layers_q <= num_layers;
          layer_idx    <= '0;
        end
        CLR: begin
          cnt_end     <= layer_len_i - CW'(1);
          cnt_end_sub <= bnd_y;
          seg_idx     <= '0;
        end
        RUN: begin
          if (cnt_fin)      seg_last_q <= 1'b1;
          else if (fs_rise) seg_last_q <= 1'b0;
        end
        SEG_ADV: begin
          cnt_end_sub <= bnd_y;
          seg_idx     <= seg_idx + CW'(1);
        end
        LDONE: if (layer_idx != num_layers_q) layer_idx <= layer_idx + LW'(1);
        default: ;
      endcase
      // Counter reset is held through CLR and released only on entry to RUN;
      // after DONE it stays released so the counter is left frozen.
      if (state_n == CLR)                        cnt_rst_n <= 1'b0;
      else if (state == CLR && state_n == RUN)   cnt_rst_n <= 1'b1;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst)                                         stall_q <= '0;
    else if (state == IDLE && start)                  stall_q <= '0;
    else if (seg_valid && !seg_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cyc = stall_q;
`else
  assign stall_cyc = '0;
`endif
endmodule

// File: tb/tb_mlp_count_seq.sv
// Directed bench for mlp_count_seq with a behavioural rip_counter_13b model.
module tb_mlp_count_seq;
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    num_layers;
  logic [12:0]   layer_len_i;
  logic [12:0]   seg_len_i;
  logic [1:0]    layer_idx;
  logic          cnt_rst_n, cnt_en;
  logic [12:0]   cnt_end, cnt_end_sub;
  logic          cnt_fin, cnt_fin_sub;
  logic          seg_valid, seg_ready, seg_last;
  logic [12:0]   seg_idx;
  logic          layer_done, done, busy;
  logic [15:0]   stall_cyc;
  mlp_ctrl_pkg::state_t state_dbg;

  logic [12:0]   len_tab [4];
  logic [12:0]   c_val;
  int            checks = 0;
  int            errors = 0;

  // observed accepted segments: {layer_idx, seg_last, seg_idx, cnt_end_sub, cnt_end}
  logic [41:0]   obs_q[$];
  logic [41:0]   exp_q[$];
  logic [1:0]    ld_q[$];
  int            done_n, timed_out, hold_seg, hold_left, hold_total, stall_bad, start_cyc;
  logic [12:0]   held_val;
  logic [1:0]    nl_run;

  always #5 clk = ~clk;

  assign layer_len_i = len_tab[layer_idx];

  // Counter model: stalls at end_count with fin=1 (priority), at end_sub_count
  // toggling fin_sub every enabled cycle.
  always @(posedge clk) begin
    if (!cnt_rst_n) begin
      c_val <= '0; cnt_fin <= 1'b0; cnt_fin_sub <= 1'b0;
    end else if (cnt_en) begin
      if (c_val == cnt_end)          cnt_fin <= 1'b1;
      else if (c_val == cnt_end_sub) cnt_fin_sub <= ~cnt_fin_sub;
      else                           c_val <= c_val + 13'd1;
    end
  end

  mlp_count_seq dut (
    .clk(clk), .rst(rst), .start(start), .num_layers(num_layers),
    .layer_len_i(layer_len_i), .seg_len_i(seg_len_i), .layer_idx(layer_idx),
    .cnt_rst_n(cnt_rst_n), .cnt_en(cnt_en), .cnt_end(cnt_end),
    .cnt_end_sub(cnt_end_sub), .cnt_fin(cnt_fin), .cnt_fin_sub(cnt_fin_sub),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_last(seg_last),
    .seg_idx(seg_idx), .layer_done(layer_done), .done(done), .busy(busy),
    .stall_cyc(stall_cyc), .state_dbg(state_dbg)
  );

  // Starts a run and monitors until done or the cycle budget expires.
  task automatic run_seq(input int max_cyc);
    obs_q.delete(); ld_q.delete();
    done_n = 0; timed_out = 0; stall_bad = 0; hold_left = hold_total;
    @(negedge clk); start = 1'b1; num_layers = nl_run;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (seg_valid && hold_seg == int'(seg_idx) && hold_left > 0) begin
        if (hold_left == hold_total) held_val = c_val;
        seg_ready = 1'b0;
        hold_left--;
        if (cnt_en !== 1'b0 || c_val !== held_val) stall_bad++;
      end else begin
        seg_ready = 1'b1;
      end
      if (seg_valid && seg_ready)
        obs_q.push_back({layer_idx, seg_last, seg_idx, cnt_end_sub, cnt_end});
      if (layer_done) ld_q.push_back(layer_idx);
      if (c == start_cyc) begin start = 1'b1; num_layers = 2'd0; end
      else if (c == start_cyc + 1) begin start = 1'b0; num_layers = nl_run; end
      if (done) begin done_n++; break; end
      @(negedge clk);
    end
    if (done_n == 0) timed_out = 1;
    seg_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state_dbg !== mlp_ctrl_pkg::IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
    checks++; if (cnt_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cnt_rst_n got %b exp 0", cnt_rst_n); end
    checks++; if ({cnt_en, seg_valid, seg_last, layer_done, done, busy} !== 6'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 000000", {cnt_en, seg_valid, seg_last, layer_done, done, busy}); end
    checks++; if ({cnt_end, cnt_end_sub, seg_idx, layer_idx} !== 41'd0) begin
      errors++; $display("FAIL rst_regs got %h exp 0", {cnt_end, cnt_end_sub, seg_idx, layer_idx}); end
    checks++; if (stall_cyc !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_cyc); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_layer;
    len_tab[0] = 13'd10; seg_len_i = 13'd4; nl_run = 2'd0;
    hold_seg = -1; hold_total = 0; start_cyc = -10;
    run_seq(200);
    exp_q = '{{2'd0, 1'b0, 13'd0, 13'h0003, 13'd9},
              {2'd0, 1'b0, 13'd1, 13'h0007, 13'd9},
              {2'd0, 1'b1, 13'd2, 13'h1FFF, 13'd9}};
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t1_timeout got %0d exp 0", timed_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t1_seg_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL t1_seg%0d got %h exp %h", i, got, exp_q[i]); end
    end
    checks++; if (ld_q.size() != 1) begin errors++; $display("FAIL t1_layer_done got %0d exp 1", ld_q.size()); end
  endtask

  task automatic test_multi_layer;
    len_tab[0] = 13'd8; len_tab[1] = 13'd5; len_tab[2] = 13'd3; seg_len_i = 13'd8; nl_run = 2'd2;
    hold_seg = -1; hold_total = 0; start_cyc = -10;
    run_seq(300);
    exp_q = '{{2'd0, 1'b1, 13'd0, 13'h1FFF, 13'd7},
              {2'd1, 1'b1, 13'd0, 13'h1FFF, 13'd4},
              {2'd2, 1'b1, 13'd0, 13'h1FFF, 13'd2}};
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t2_timeout got %0d exp 0", timed_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t2_seg_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL t2_seg%0d got %h exp %h", i, got, exp_q[i]); end
    end
    checks++; if (ld_q.size() != 3) begin errors++; $display("FAIL t2_layer_done got %0d exp 3", ld_q.size()); end
  endtask

  task automatic test_fin_priority;
    len_tab[0] = 13'd6; seg_len_i = 13'd3; nl_run = 2'd0;
    hold_seg = -1; hold_total = 0; start_cyc = -10;
    run_seq(200);
    exp_q = '{{2'd0, 1'b0, 13'd0, 13'h0002, 13'd5},
              {2'd0, 1'b1, 13'd1, 13'h1FFF, 13'd5}};
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t3_timeout got %0d exp 0", timed_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t3_seg_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL t3_seg%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_stall;
    logic [15:0] exp_stall;
`ifdef SEQ_STALL_CNT_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif
    len_tab[0] = 13'd10; seg_len_i = 13'd4; nl_run = 2'd0;
    hold_seg = 1; hold_total = 7; start_cyc = -10;
    run_seq(300);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t4_timeout got %0d exp 0", timed_out); end
    checks++; if (hold_left !== 0) begin errors++; $display("FAIL t4_hold_used got %0d exp 0", hold_left); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL t4_frozen got %0d bad cycles exp 0", stall_bad); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL t4_seg_count got %0d exp 3", obs_q.size()); end
    checks++; if (stall_cyc !== exp_stall) begin errors++; $display("FAIL t4_stall_cyc got %0d exp %0d", stall_cyc, exp_stall); end
  endtask

  task automatic test_skip_and_busy_start;
    len_tab[0] = 13'd4; len_tab[1] = 13'd0; len_tab[2] = 13'd4; seg_len_i = 13'd2; nl_run = 2'd2;
    hold_seg = -1; hold_total = 0; start_cyc = 3;
    run_seq(300);
    start_cyc = -10;
    exp_q = '{{2'd0, 1'b0, 13'd0, 13'h0001, 13'd3},
              {2'd0, 1'b1, 13'd1, 13'h1FFF, 13'd3},
              {2'd2, 1'b0, 13'd0, 13'h0001, 13'd3},
              {2'd2, 1'b1, 13'd1, 13'h1FFF, 13'd3}};
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t5_timeout got %0d exp 0", timed_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t5_seg_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL t5_seg%0d got %h exp %h", i, got, exp_q[i]); end
    end
    checks++; if (ld_q.size() != 3) begin errors++; $display("FAIL t5_layer_done got %0d exp 3", ld_q.size()); end
    checks++; if (ld_q.size() < 2 || ld_q[1] !== 2'd1) begin errors++; $display("FAIL t5_skip_layer got %0d exp 1", (ld_q.size() < 2) ? 3 : int'(ld_q[1])); end
  endtask

  task automatic test_reset_mid_run;
    int seen, pulses;
    len_tab[0] = 13'd10; seg_len_i = 13'd4; num_layers = 2'd0;
    seen = 0; pulses = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; seg_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (seg_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL t6_reach_wait got %0d exp 1", seen); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== mlp_ctrl_pkg::IDLE) begin errors++; $display("FAIL t6_state got %0d exp 0", state_dbg); end
    checks++; if ({cnt_rst_n, cnt_en, seg_valid, seg_last, layer_done, done, busy} !== 7'b0) begin
      errors++; $display("FAIL t6_flags got %b exp 0000000", {cnt_rst_n, cnt_en, seg_valid, seg_last, layer_done, done, busy}); end
    checks++; if ({cnt_end, cnt_end_sub, seg_idx, layer_idx} !== 41'd0) begin
      errors++; $display("FAIL t6_regs got %h exp 0", {cnt_end, cnt_end_sub, seg_idx, layer_idx}); end
    rst = 1'b1; seg_ready = 1'b1;
    repeat (5) begin
      if (done || layer_done) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL t6_no_done got %0d exp 0", pulses); end
    nl_run = 2'd0; hold_seg = -1; hold_total = 0; start_cyc = -10;
    run_seq(200);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL t6_rerun_timeout got %0d exp 0", timed_out); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL t6_rerun_segs got %0d exp 3", obs_q.size()); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_layers = '0; seg_len_i = 13'd1; seg_ready = 1'b1;
    for (int i = 0; i < 4; i++) len_tab[i] = 13'd1;
    hold_seg = -1; hold_total = 0; start_cyc = -10; nl_run = 2'd0;
    test_reset;
    test_single_layer;
    test_multi_layer;
    test_fin_priority;
    test_stall;
    test_skip_and_busy_start;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
